// File: rtl/mdu_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: the EX-stage ALU control
// codes it reuses, and the RV32M funct3 codes it accepts.
package mdu_sequencer_pkg;

   localparam logic [3:0] ADD  = 4'b0000;
   localparam logic [3:0] SUB  = 4'b1000;
   localparam logic [3:0] REG1 = 4'b1111;

   localparam logic [2:0] MDU_MUL  = 3'b000;
   localparam logic [2:0] MDU_DIV  = 3'b100;
   localparam logic [2:0] MDU_DIVU = 3'b101;
   localparam logic [2:0] MDU_REM  = 3'b110;
   localparam logic [2:0] MDU_REMU = 3'b111;

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide controller. Borrows the EX-stage ALU for a fixed
// 36-cycle schedule: operand abs, 32 shift-add / restoring-subtract steps, sign fix.
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            alu_req,
   output logic [XLEN-1:0] alu_op1,
   output logic [XLEN-1:0] alu_op2,
   output logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_out
);

   localparam int CNT_W = $clog2(ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_FIX, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic [XLEN-1:0]   a_q, a_d;        // rs1, then |A|, then M (MUL) or Q (DIV/REM)
   logic [XLEN-1:0]   b_q, b_d;        // rs2, then |B| (shifted left during MUL)
   logic [XLEN-1:0]   acc_q, acc_d;    // product accumulator or partial remainder R
   logic [XLEN-1:0]   result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic            is_mul, is_divrem, is_div_q, neg_fix;
   logic [XLEN-1:0] t_val, fix_val;
   logic            lt;

   assign is_mul    = (op_q == MDU_MUL);
   assign is_divrem = op_q[2];
   assign is_div_q  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
   assign t_val     = {acc_q[XLEN-2:0], a_q[XLEN-1]};
   assign fix_val   = is_mul ? acc_q : (is_div_q ? a_q : acc_q);
   assign neg_fix   = ((op_q == MDU_DIV) && (neg_a_q ^ neg_b_q) && (b_q != '0)) ||
                      ((op_q == MDU_REM) && neg_a_q);

   // Borrow out of t - B, with acc[31] standing in for the 33rd dividend bit.
   assign lt = ~acc_q[XLEN-1] &
               ((~t_val[XLEN-1] & b_q[XLEN-1]) |
                (~(t_val[XLEN-1] ^ b_q[XLEN-1]) & alu_out[XLEN-1]));

   always_comb begin
      alu_op1  = '0;
      alu_op2  = '0;
      alu_ctrl = REG1;
      unique case (state_q)
         S_ABS_A: begin
            alu_op1  = neg_a_q ? '0 : a_q;
            alu_op2  = neg_a_q ? a_q : '0;
            alu_ctrl = neg_a_q ? SUB : REG1;
         end
         S_ABS_B: begin
            alu_op1  = neg_b_q ? '0 : b_q;
            alu_op2  = neg_b_q ? b_q : '0;
            alu_ctrl = neg_b_q ? SUB : REG1;
         end
         S_ITER: begin
            if (is_mul) begin
               alu_op1  = acc_q;
               alu_op2  = a_q[0] ? b_q : '0;
               alu_ctrl = ADD;
            end else if (is_divrem) begin
               alu_op1  = t_val;
               alu_op2  = b_q;
               alu_ctrl = SUB;
            end
         end
         S_FIX: begin
            if (is_mul || is_divrem) begin
               alu_op1  = neg_fix ? '0 : fix_val;
               alu_op2  = neg_fix ? fix_val : '0;
               alu_ctrl = neg_fix ? SUB : REG1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = rs1;
               b_d     = rs2;
               neg_a_d = is_signed_op(op) & rs1[XLEN-1];
               neg_b_d = is_signed_op(op) & rs2[XLEN-1];
               state_d = S_ABS_A;
            end
         end
         S_ABS_A: begin
            a_d     = alu_out;
            state_d = S_ABS_B;
         end
         S_ABS_B: begin
            b_d     = alu_out;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (is_mul) begin
               acc_d = alu_out;
               b_d   = b_q << 1;
               a_d   = a_q >> 1;
            end else if (is_divrem) begin
               acc_d = lt ? t_val : alu_out;
               a_d   = {a_q[XLEN-2:0], ~lt};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            result_d = alu_out;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // An abort drops everything in flight, including a start in the same cycle.
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign alu_req = busy;
   assign result  = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: models the EX ALU, issues directed and random RV32M
// ops, and scores each done pulse against an arithmetic reference model.
module tb_mdu_sequencer;
   import mdu_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, start;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic        busy, done, alu_req;
   logic [31:0] result, alu_op1, alu_op2, alu_out;
   logic [3:0]  alu_ctrl;

   mdu_sequencer #(.XLEN(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
      .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result),
      .alu_req(alu_req), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_ctrl(alu_ctrl), .alu_out(alu_out)
   );

   // clock / reset / cycle count
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // EX-stage ALU stand-in
   always_comb begin
      alu_out = '0;
      case (alu_ctrl)
         ADD:     alu_out = alu_op1 + alu_op2;
         SUB:     alu_out = alu_op1 - alu_op2;
         REG1:    alu_out = alu_op1;
         default: alu_out = '0;
      endcase
   end

   // scoreboard state
   logic [31:0] exp_q[$];
   int          stamp_q[$];
   int          checks = 0;
   int          passes = 0;
   int          busy_run = 0;
   logic [31:0] last_exp = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // RV32M results straight from the ISA definition
   function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a,
                                                input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'b000:  return a * b;
         3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         3'b111:  return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      logic [31:0] e;
      int          s;
      if (rst) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         else busy_run = 0;
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               s = stamp_q.pop_front();
               check("result", result, e);
               check("latency", 32'(cyc - s), 32'd36);
               check("busy_span", 32'(busy_run), 32'd36);
               check("alu_req_eq_busy", {31'b0, alu_req}, {31'b0, busy});
            end
         end
      end
   end

   // driver tasks (inputs change on the falling edge)
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_done);
      op = f; rs1 = a; rs2 = b; start = 1'b1;
      if (expect_done) begin
         exp_q.push_back(model_result(f, a, b));
         stamp_q.push_back(cyc);
         last_exp = model_result(f, a, b);
      end
      @(negedge clk);
      start = 1'b0;
      rs1 = $urandom; rs2 = $urandom;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) begin seen = 1; break; end
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         $display("FAIL done_timeout: got no done expected done within 60 cycles (cycle %0d)", cyc);
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      issue(f, a, b, 1'b1);
      wait_done();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_alu_req"}, {31'b0, alu_req}, 32'd0);
      check({tag, "_result"}, result, 32'd0);
      check({tag, "_alu_op1"}, alu_op1, 32'd0);
      check({tag, "_alu_op2"}, alu_op2, 32'd0);
      check({tag, "_alu_ctrl"}, {28'b0, alu_ctrl}, {28'b0, REG1});
   endtask

   logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 200));
         1:       return specials[$urandom_range(0, 4)];
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // directed vectors, issued back to back
      run(MDU_MUL, 32'd7, 32'd6);
      run(MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(MDU_MUL, 32'h8000_0000, 32'd2);
      run(MDU_DIVU, 32'd100, 32'd7);
      run(MDU_REMU, 32'd100, 32'd7);
      run(MDU_DIV, -32'sd7, 32'd2);
      run(MDU_REM, -32'sd7, 32'd2);
      run(MDU_DIVU, 32'd5, 32'd0);
      run(MDU_REMU, 32'd5, 32'd0);
      run(MDU_DIV, -32'sd5, 32'd0);
      run(MDU_REM, -32'sd5, 32'd0);
      run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      run(3'b010, 32'd9, 32'd3);

      // flush at cycle 10 of a run: no done, idle next cycle, result kept
      issue(MDU_MUL, 32'd1234, 32'd5678, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_alu_req", {31'b0, alu_req}, 32'd0);
      check("flush_result", result, last_exp);
      repeat (40) @(negedge clk);
      check("flush_result_kept", result, last_exp);

      // flush together with start in IDLE: nothing accepted
      flush = 1'b1;
      issue(MDU_DIVU, 32'd50, 32'd3, 1'b0);
      flush = 1'b0;
      check("flush_start_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(negedge clk);

      // start while busy is ignored
      issue(MDU_DIVU, 32'd1000, 32'd9, 1'b1);
      repeat (5) @(negedge clk);
      op = MDU_MUL; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (45) @(negedge clk);

      // reset mid-ITER clears every output on the following cycle
      issue(MDU_MUL, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      rst = 1'b0;
      @(negedge clk);

      // randomized traffic, including unsupported opcodes
      for (int n = 0; n < 40; n++) begin
         logic [2:0] f;
         f = 3'($urandom_range(0, 7));
         run(f, rand_operand(), rand_operand());
      end

      repeat (5) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
